vfu_req_sequencer: RTL and testbench

Receiving end of the launcher-to-VFU request channel. It accepts one `vfu_req_t` per instruction over a valid/ready handshake and splits the instruction's `vlB` bytes into lane-width beats. Each beat pops the required operand-queue heads and is handed to the VFU datapath. After the last beat it emits the single-cycle done report (`insn_id`, `use_vd`, `vd`) consumed by the scoreboard and the commit controller. One instance sits at the front of each VFU.

---
 rtl/vfu_req_sequencer.sv | 117 +++++++++++
 tb/tb_vfu_req_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vfu_req_sequencer.sv
// vfu_req_sequencer: splits one VFU request into lane-width beats, then pulses a done report.
// Define VFU_SEQ_BACKTOBACK_EN to also accept requests in DONE, removing the bubble between instructions.
package vfu_pkg;
  typedef logic [4:0]  vop_t;
  typedef logic [1:0]  vew_t;
  typedef logic [9:0]  vlb_t;
  typedef logic [7:0]  vrf_addr_t;
  typedef logic [15:0] scalar_t;
  typedef logic [3:0]  insn_id_t;
  typedef logic [4:0]  vreg_t;
  typedef struct packed {
    vop_t      vop;
    vew_t      vew;
    vlb_t      vlB;
    logic [1:0] use_vs;
    vrf_addr_t waddr;
    scalar_t   scalar_op;
    insn_id_t  insn_id;
    vreg_t     vd;
  } vfu_req_t;
endpackage

module vfu_req_sequencer
  import vfu_pkg::*;
#(
  parameter int LaneBytes = 8,
  parameter int VlBWidth  = $bits(vlb_t)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            vfu_req_valid_i,
  output logic            vfu_req_ready_o,
  input  vfu_req_t        vfu_req_i,
  input  logic [1:0]      opq_valid_i,
  output logic [1:0]      opq_ready_o,
  output logic            beat_valid_o,
  input  logic            beat_ready_i,
  output vop_t            beat_vop_o,
  output vew_t            beat_vew_o,
  output scalar_t         beat_scalar_o,
  output insn_id_t        beat_id_o,
  output vrf_addr_t       beat_waddr_o,
  output logic [LaneBytes-1:0] beat_be_o,
  output logic            beat_last_o,
  output logic            done_o,
  output insn_id_t        done_id_o,
  output logic            done_use_vd_o,
  output vreg_t           done_vd_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [VlBWidth-1:0] LB = VlBWidth'(LaneBytes);
  state_t               r_state;
  vop_t                 r_vop;
  vew_t                 r_vew;
  scalar_t              r_scalar;
  insn_id_t             r_id;
  vreg_t                r_vd;
  logic [1:0]           r_use;
  logic [VlBWidth-1:0]  r_rem;
  vrf_addr_t            r_addr;
  logic                 w_accept, w_fire, w_last;
  logic [VlBWidth-1:0]  w_rem_nxt;
`ifdef VFU_SEQ_BACKTOBACK_EN
  assign vfu_req_ready_o = (r_state == IDLE) || (r_state == DONE);
`else
  assign vfu_req_ready_o = (r_state == IDLE);
`endif
  assign w_accept      = vfu_req_valid_i && vfu_req_ready_o;
  assign beat_valid_o  = (r_state == RUN) && &(opq_valid_i | ~r_use);
  assign w_fire        = beat_valid_o && beat_ready_i;
  assign opq_ready_o   = {2{w_fire}} & r_use;
  assign w_last        = r_rem <= LB;
  assign w_rem_nxt     = r_rem > LB ? r_rem - LB : '0;
  assign beat_last_o   = (r_state == RUN) && w_last;
  assign beat_waddr_o  = r_addr;
  assign beat_vop_o    = r_vop;
  assign beat_vew_o    = r_vew;
  assign beat_scalar_o = r_scalar;
  assign beat_id_o     = r_id;
  assign done_o        = r_state == DONE;
  assign done_use_vd_o = r_state == DONE;
  assign done_id_o     = r_id;
  assign done_vd_o     = r_vd;
  // byte i is live while more than i bytes remain
  for (genvar i = 0; i < LaneBytes; i++) begin : g_be
    assign beat_be_o[i] = r_rem > VlBWidth'(i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_vop    <= '0;
      r_vew    <= '0;
      r_scalar <= '0;
      r_id     <= '0;
      r_vd     <= '0;
      r_use    <= '0;
      r_rem    <= '0;
      r_addr   <= '0;
    end else if (w_accept) begin
      r_vop    <= vfu_req_i.vop;
      r_vew    <= vfu_req_i.vew;
      r_scalar <= vfu_req_i.scalar_op;
      r_id     <= vfu_req_i.insn_id;
      r_vd     <= vfu_req_i.vd;
      r_use    <= vfu_req_i.use_vs;
      r_rem    <= VlBWidth'(vfu_req_i.vlB);
      r_addr   <= vfu_req_i.waddr;
      r_state  <= vfu_req_i.vlB == '0 ? DONE : RUN;
    end else if (w_fire) begin
      r_addr   <= r_addr + 1'b1;
      r_rem    <= w_rem_nxt;
      r_state  <= w_last ? DONE : RUN;
    end else if (r_state == DONE) begin
      r_state  <= IDLE;
    end
  end
endmodule

// File: tb/tb_vfu_req_sequencer.sv
// tb_vfu_req_sequencer: directed + random stimulus checked against a beat-list reference model.
module tb_vfu_req_sequencer;
  import vfu_pkg::*;
  localparam int LB = 8;
`ifdef VFU_SEQ_BACKTOBACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  vfu_req_t req = '0;
  logic [1:0] opq_valid = 2'b11, opq_ready;
  logic beat_valid, beat_ready = 1, beat_last, done, done_use_vd;
  vop_t beat_vop;
  vew_t beat_vew;
  scalar_t beat_scalar;
  insn_id_t beat_id, done_id;
  vrf_addr_t beat_waddr;
  logic [LB-1:0] beat_be;
  vreg_t done_vd;
  int total = 0, bad = 0;
  bit rnd = 0;

  vfu_req_sequencer #(.LaneBytes(LB)) dut (
    .clk_i(clk), .rst_i(rst),
    .vfu_req_valid_i(req_valid), .vfu_req_ready_o(req_ready), .vfu_req_i(req),
    .opq_valid_i(opq_valid), .opq_ready_o(opq_ready),
    .beat_valid_o(beat_valid), .beat_ready_i(beat_ready),
    .beat_vop_o(beat_vop), .beat_vew_o(beat_vew), .beat_scalar_o(beat_scalar), .beat_id_o(beat_id),
    .beat_waddr_o(beat_waddr), .beat_be_o(beat_be), .beat_last_o(beat_last),
    .done_o(done), .done_id_o(done_id), .done_use_vd_o(done_use_vd), .done_vd_o(done_vd)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] be; logic [7:0] wa; logic last;} beat_t;
  beat_t m_q[$];
  vfu_req_t m_req = '0;
  bit m_done = 0, m_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: inputs already driven at the negedge; check, then advance the model across the edge
  task automatic cyc();
    bit busy, rdy, vld, fire;
    int n;
    if (rnd) begin
      opq_valid = 2'($urandom);
      beat_ready = 1'($urandom);
    end
    #1;
    busy = m_q.size() > 0;
    rdy  = !busy && (!m_done || BTB);
    vld  = busy && ((opq_valid & m_req.use_vs) == m_req.use_vs);
    fire = vld && beat_ready;
    chk("req_ready", req_ready, rdy);
    chk("beat_valid", beat_valid, vld);
    chk("opq_ready", opq_ready, fire ? m_req.use_vs : 2'b00);
    chk("done", done, m_done);
    chk("done_use_vd", done_use_vd, m_done);
    chk("beat_last", beat_last, busy ? m_q[0].last : 1'b0);
    if (busy) begin
      chk("beat_be", beat_be, m_q[0].be);
      chk("beat_waddr", beat_waddr, m_q[0].wa);
      chk("beat_vop", beat_vop, m_req.vop);
      chk("beat_vew", beat_vew, m_req.vew);
      chk("beat_scalar", beat_scalar, m_req.scalar_op);
      chk("beat_id", beat_id, m_req.insn_id);
    end
    if (m_done) begin
      chk("done_id", done_id, m_req.insn_id);
      chk("done_vd", done_vd, m_req.vd);
    end
    m_acc = req_valid && rdy && !rst;
    if (rst) begin
      m_q.delete();
      m_done = 0;
    end else begin
      m_done = 0;
      if (fire) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1;
      end
      if (m_acc) begin
        m_req = req;
        n = (int'(req.vlB) + LB - 1) / LB;
        if (n == 0) m_done = 1;
        for (int b = 0; b < n; b++) begin
          int bytes;
          beat_t e;
          bytes = int'(req.vlB) - b * LB;
          if (bytes > LB) bytes = LB;
          e.be = 8'((1 << bytes) - 1);
          e.wa = 8'(int'(req.waddr) + b);
          e.last = (b == n - 1);
          m_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input vfu_req_t r);
    req = r;
    req_valid = 1;
    m_acc = 0;
    for (int i = 0; i < 200 && !m_acc; i++) cyc();
    total++;
    if (!m_acc) begin
      bad++;
      $display("FAIL accept_timeout observed=not-accepted expected=accepted");
    end
    req_valid = 0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300 && (m_q.size() > 0 || m_done); i++) cyc();
    cyc();
    total++;
    if (i >= 300) begin
      bad++;
      $display("FAIL drain_timeout observed=busy expected=idle");
    end
  endtask

  function automatic vfu_req_t mk(input int vlb, input logic [1:0] use_vs, input int wa);
    vfu_req_t r;
    r.vop = 5'($urandom);
    r.vew = 2'($urandom);
    r.vlB = 10'(vlb);
    r.use_vs = use_vs;
    r.waddr = 8'(wa);
    r.scalar_op = 16'($urandom);
    r.insn_id = 4'($urandom);
    r.vd = 5'($urandom);
    return r;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    // idle after reset: ready high, everything else zero
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      chk("idle_be", beat_be, 0);
      chk("idle_waddr", beat_waddr, 0);
      chk("idle_id", done_id, 0);
      chk("idle_vd", done_vd, 0);
    end
    // 20 bytes, both operands
    send(mk(20, 2'b11, 8'h40));
    drain();
    // stall on vs1 while vs2 is valid but unused
    send(mk(24, 2'b01, 8'h10));
    opq_valid = 2'b11;
    cyc();
    opq_valid = 2'b10;
    repeat (4) cyc();
    opq_valid = 2'b11;
    drain();
    // zero-length instruction
    send(mk(0, 2'b11, 8'h05));
    drain();
    // two queued 8-byte requests
    send(mk(8, 2'b10, 8'h20));
    send(mk(8, 2'b11, 8'h30));
    drain();
    // reset during beat 2 of 4
    send(mk(32, 2'b11, 8'hFE));
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    drain();
    // random traffic with back-pressure and address wrap
    rnd = 1;
    for (int k = 0; k < 30; k++) begin
      send(mk($urandom_range(0, 40), 2'($urandom), $urandom_range(0, 3) == 0 ? $urandom_range(250, 255) : $urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
